// File: rtl/wisc_pkg.sv
// Types and constants shared by the pipeline control slice.
package wisc_pkg;

    localparam int REG_ID_W = 4;
    localparam logic [REG_ID_W-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MEM_WAIT   = 2'd1,
        HALT_DRAIN = 2'd2,
        HALTED     = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational detection of load-use and register-branch hazards
// against the instructions currently shadowed in EX and MEM.
module hazard_detect
    import wisc_pkg::*;
(
    input  logic                i_id_valid,
    input  logic [REG_ID_W-1:0] i_src_a,
    input  logic [REG_ID_W-1:0] i_src_b,
    input  logic                i_src_a_used,
    input  logic                i_src_b_used,
    input  logic                i_is_br_reg,
    input  logic                i_ex_vld,
    input  logic [REG_ID_W-1:0] i_ex_dst,
    input  logic                i_ex_wr,
    input  logic                i_ex_load,
    input  logic                i_mem_vld,
    input  logic [REG_ID_W-1:0] i_mem_dst,
    input  logic                i_mem_wr,
    input  logic                i_mem_load,
    output logic                o_load_use,
    output logic                o_br_hz
);
    logic w_a_hit_ex;
    logic w_b_hit_ex;
    logic w_br_ex;
    logic w_br_mem;

    // R0 is hardwired, so a match on it never creates a dependency.
    assign w_a_hit_ex = i_src_a_used & (i_src_a != ZERO_REG) & (i_src_a == i_ex_dst);
    assign w_b_hit_ex = i_src_b_used & (i_src_b != ZERO_REG) & (i_src_b == i_ex_dst);

    assign o_load_use = i_id_valid & i_ex_vld & i_ex_load & (w_a_hit_ex | w_b_hit_ex);

    assign w_br_ex  = i_ex_vld & i_ex_wr & (i_src_a == i_ex_dst);
    assign w_br_mem = i_mem_vld & i_mem_load & i_mem_wr & (i_src_a == i_mem_dst);
    assign o_br_hz  = i_is_br_reg & (i_src_a != ZERO_REG) & (w_br_ex | w_br_mem);

endmodule

// File: rtl/pipeline_ctrl_unit.sv
// Pipeline control: stall/bubble/flush/freeze generation, memory-wait and
// halt-drain sequencing, and a saturating count of non-advancing cycles.
module pipeline_ctrl_unit
    import wisc_pkg::*;
#(
    parameter int STALL_CNT_W  = 16,
    parameter int DRAIN_CYCLES = 3
)
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic [REG_ID_W-1:0]    id_srcA,
    input  logic [REG_ID_W-1:0]    id_srcB,
    input  logic                   id_srcA_used,
    input  logic                   id_srcB_used,
    input  logic [REG_ID_W-1:0]    id_dst,
    input  logic                   id_wr_en,
    input  logic                   id_is_load,
    input  logic                   id_is_br_reg,
    input  logic                   id_br_taken,
    input  logic                   id_hlt,
    input  logic                   mem_req,
    input  logic                   mem_ready,
    output logic                   pc_en,
    output logic                   if_id_en,
    output logic                   if_id_flush,
    output logic                   id_ex_en,
    output logic                   id_ex_bubble,
    output logic                   ex_mem_en,
    output logic                   mem_wb_en,
    output logic                   mem_wb_bubble,
    output logic                   halted,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    ctrl_state_t r_state;
    ctrl_state_t w_next;

    logic                   r_ex_vld, r_ex_wr, r_ex_load;
    logic                   r_mem_vld, r_mem_wr, r_mem_load;
    logic [REG_ID_W-1:0]    r_ex_dst, r_mem_dst;
    logic [DRAIN_W-1:0]     r_drain;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic w_load_use, w_br_hz, w_active, w_freeze, w_stall_id;
    logic w_hlt_go, w_flush_req, w_drain_done;

    hazard_detect u_hazard_detect (
        .i_id_valid   (id_valid),
        .i_src_a      (id_srcA),
        .i_src_b      (id_srcB),
        .i_src_a_used (id_srcA_used),
        .i_src_b_used (id_srcB_used),
        .i_is_br_reg  (id_is_br_reg),
        .i_ex_vld     (r_ex_vld),
        .i_ex_dst     (r_ex_dst),
        .i_ex_wr      (r_ex_wr),
        .i_ex_load    (r_ex_load),
        .i_mem_vld    (r_mem_vld),
        .i_mem_dst    (r_mem_dst),
        .i_mem_wr     (r_mem_wr),
        .i_mem_load   (r_mem_load),
        .o_load_use   (w_load_use),
        .o_br_hz      (w_br_hz)
    );

    // The cycle that releases MEM_WAIT behaves like an ordinary RUN cycle.
    assign w_active = (r_state == RUN) | (r_state == MEM_WAIT);

    // A memory wait during the drain also freezes, so the drain only counts real progress.
    assign w_freeze = (((r_state == RUN) | (r_state == HALT_DRAIN)) & mem_req & ~mem_ready)
                    | ((r_state == MEM_WAIT) & ~mem_ready);

    assign w_stall_id   = w_active & (w_load_use | w_br_hz);
    assign w_flush_req  = w_active & id_br_taken & id_valid & ~w_stall_id & ~w_freeze;
    assign w_hlt_go     = w_active & id_hlt & id_valid & ~id_br_taken & ~w_stall_id & ~w_freeze;
    assign w_drain_done = (r_drain == DRAIN_LAST);
    assign stall_cnt    = r_stall_cnt;

    always_comb begin
        w_next        = r_state;
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_en      = 1'b1;
        id_ex_bubble  = 1'b0;
        ex_mem_en     = 1'b1;
        mem_wb_en     = 1'b1;
        mem_wb_bubble = 1'b0;
        halted        = 1'b0;

        case (r_state)
            RUN:        if (w_freeze) w_next = MEM_WAIT;
                        else if (w_hlt_go) w_next = HALT_DRAIN;
            MEM_WAIT:   if (mem_ready) w_next = w_hlt_go ? HALT_DRAIN : RUN;
            HALT_DRAIN: if (!w_freeze && w_drain_done) w_next = HALTED;
            HALTED:     w_next = HALTED;
            default:    w_next = RUN;
        endcase

        if (r_state == HALTED) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
            halted = 1'b1;
        end else if (w_freeze) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
            mem_wb_bubble = 1'b1;
        end else if ((r_state == HALT_DRAIN) || w_stall_id) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (w_flush_req) begin
            if_id_flush = 1'b1;
        end

        // Reset overrides everything so the datapath sees a plain "advance" pattern.
        if (!rst_n) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
            {if_id_flush, id_ex_bubble, mem_wb_bubble, halted} = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_drain     <= '0;
            r_stall_cnt <= '0;
            r_ex_vld    <= 1'b0;
            r_mem_vld   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_hlt_go)
                r_drain <= '0;
            else if ((r_state == HALT_DRAIN) && !w_freeze && !w_drain_done)
                r_drain <= r_drain + DRAIN_W'(1);
            if ((w_freeze || w_stall_id) && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
            if (id_ex_en)
                r_ex_vld <= id_valid & ~id_ex_bubble;
            if (ex_mem_en)
                r_mem_vld <= r_ex_vld;
        end
    end

    // Shadow payload is only meaningful when the matching valid is set.
    always_ff @(posedge clk) begin
        if (id_ex_en) begin
            r_ex_dst  <= id_dst;
            r_ex_wr   <= id_wr_en;
            r_ex_load <= id_is_load;
        end
        if (ex_mem_en) begin
            r_mem_dst  <= r_ex_dst;
            r_mem_wr   <= r_ex_wr;
            r_mem_load <= r_ex_load;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// Directed scenarios plus randomized traffic against a cycle-level model of
// the pipeline control rules.
module tb_pipeline_ctrl_unit;
    localparam int CW = 4;
    localparam int DC = 3;
    localparam int CNT_MAX = (1 << CW) - 1;
    localparam logic [8:0] PAT_RUN    = 9'b110101100;
    localparam logic [8:0] PAT_FLUSH  = 9'b111101100;
    localparam logic [8:0] PAT_STALL  = 9'b000111100;
    localparam logic [8:0] PAT_FREEZE = 9'b000000010;
    localparam logic [8:0] PAT_HALTED = 9'b000000001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic id_valid, id_srcA_used, id_srcB_used, id_wr_en, id_is_load;
    logic id_is_br_reg, id_br_taken, id_hlt, mem_req, mem_ready;
    logic [3:0] id_srcA, id_srcB, id_dst;
    logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble;
    logic ex_mem_en, mem_wb_en, mem_wb_bubble, halted;
    logic [CW-1:0] stall_cnt;
    logic [8:0] outs;

    assign outs = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
                   ex_mem_en, mem_wb_en, mem_wb_bubble, halted};

    pipeline_ctrl_unit #(.STALL_CNT_W(CW), .DRAIN_CYCLES(DC)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_srcA(id_srcA), .id_srcB(id_srcB),
        .id_srcA_used(id_srcA_used), .id_srcB_used(id_srcB_used),
        .id_dst(id_dst), .id_wr_en(id_wr_en), .id_is_load(id_is_load),
        .id_is_br_reg(id_is_br_reg), .id_br_taken(id_br_taken), .id_hlt(id_hlt),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_bubble(id_ex_bubble), .ex_mem_en(ex_mem_en),
        .mem_wb_en(mem_wb_en), .mem_wb_bubble(mem_wb_bubble), .halted(halted),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model: what sits in EX and MEM, plus mode flags.
    typedef struct packed { logic vld; logic [3:0] dst; logic wr; logic ld; } slot_t;
    slot_t m_ex, m_mem;
    bit    m_wait, m_halted;
    int    m_drain_left, m_cnt;
    bit    e_frz, e_stl, e_hlt_go;
    logic [8:0] e_ctrl;

    task automatic model_reset();
        m_ex = '0; m_mem = '0; m_wait = 0; m_halted = 0; m_drain_left = 0; m_cnt = 0;
    endtask

    task automatic model_eval();
        bit lu, bh, active, flush;
        lu = id_valid && m_ex.vld && m_ex.ld &&
             ((id_srcA_used && id_srcA != 0 && id_srcA == m_ex.dst) ||
              (id_srcB_used && id_srcB != 0 && id_srcB == m_ex.dst));
        bh = id_is_br_reg && id_srcA != 0 &&
             ((m_ex.vld && m_ex.wr && m_ex.dst == id_srcA) ||
              (m_mem.vld && m_mem.ld && m_mem.wr && m_mem.dst == id_srcA));
        active   = !m_halted && m_drain_left == 0;
        e_frz    = !m_halted && !mem_ready && (mem_req || m_wait);
        e_stl    = active && (lu || bh);
        flush    = active && id_br_taken && id_valid && !e_stl && !e_frz;
        e_hlt_go = active && id_hlt && id_valid && !id_br_taken && !e_stl && !e_frz;
        if (m_halted)                         e_ctrl = PAT_HALTED;
        else if (e_frz)                       e_ctrl = PAT_FREEZE;
        else if (m_drain_left > 0 || e_stl)   e_ctrl = PAT_STALL;
        else if (flush)                       e_ctrl = PAT_FLUSH;
        else                                  e_ctrl = PAT_RUN;
    endtask

    task automatic model_update();
        bit draining;
        draining = m_drain_left > 0;
        if ((e_frz || e_stl) && m_cnt < CNT_MAX) m_cnt++;
        if (!m_halted && !e_frz) begin
            m_mem = m_ex;
            m_ex  = (draining || e_stl) ? slot_t'('0) : {id_valid, id_dst, id_wr_en, id_is_load};
        end
        if (!m_halted && !draining) m_wait = e_frz;
        if (e_hlt_go) m_drain_left = DC;
        else if (draining && !e_frz) begin
            m_drain_left--;
            if (m_drain_left == 0) m_halted = 1;
        end
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic step();
        @(negedge clk);
        model_eval();
        check("ctrl", outs, e_ctrl);
        check("cnt", stall_cnt, m_cnt);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_idle();
        {id_valid, id_srcA_used, id_srcB_used, id_wr_en, id_is_load} = '0;
        {id_is_br_reg, id_br_taken, id_hlt, mem_req, mem_ready} = '0;
        id_srcA = '0; id_srcB = '0; id_dst = '0;
    endtask

    task automatic put(input logic [3:0] a, input logic au, input logic [3:0] b, input logic bu,
                       input logic [3:0] d, input logic wr, input logic ld,
                       input logic br, input logic tk, input logic hl);
        id_valid = 1'b1;
        id_srcA = a; id_srcA_used = au; id_srcB = b; id_srcB_used = bu;
        id_dst = d; id_wr_en = wr; id_is_load = ld;
        id_is_br_reg = br; id_br_taken = tk; id_hlt = hl;
    endtask

    task automatic do_reset();
        set_idle();
        mem_req = 1'b1;
        rst_n = 1'b0;
        #1;
        check("rst_ctrl", outs, PAT_RUN);
        check("rst_cnt", stall_cnt, 0);
        model_reset();
        @(negedge clk);
        mem_req = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        set_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // LW R3 ; ADD R4,R3,R5 -> one load-use stall
        put(4'd0, 0, 4'd0, 0, 4'd3, 1, 1, 0, 0, 0); step();
        put(4'd3, 1, 4'd5, 1, 4'd4, 1, 0, 0, 0, 0);
        #1; check("lu_pc_en", pc_en, 0); check("lu_bubble", id_ex_bubble, 1);
        step();
        #1; check("lu_release", pc_en, 1); check("lu_cnt", stall_cnt, 1);
        step();
        set_idle(); step(); step();

        // ADD R2 ; BR R2 -> one cycle
        put(4'd1, 1, 4'd1, 1, 4'd2, 1, 0, 0, 0, 0); step();
        put(4'd2, 1, 4'd0, 0, 4'd0, 0, 0, 1, 0, 0);
        #1; check("brhz_ex", pc_en, 0);
        step();
        #1; check("brhz_ex_done", pc_en, 1);
        step();
        set_idle(); step(); step();

        // LW R2 ; BR R2 -> two cycles
        put(4'd0, 0, 4'd0, 0, 4'd2, 1, 1, 0, 0, 0); step();
        put(4'd2, 1, 4'd0, 0, 4'd0, 0, 0, 1, 0, 0);
        #1; check("brlw_1", pc_en, 0); step();
        #1; check("brlw_2", pc_en, 0); step();
        #1; check("brlw_done", pc_en, 1); step();
        set_idle(); step();

        // Memory wait for four cycles
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            #1; check("mw_en", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 0);
            step();
        end
        mem_ready = 1;
        #1; check("mw_release", pc_en, 1); check("mw_cnt", stall_cnt, 4);
        step();
        set_idle(); step();

        // Load-use coincident with a memory wait
        do_reset();
        put(4'd0, 0, 4'd0, 0, 4'd3, 1, 1, 0, 0, 0); step();
        put(4'd3, 1, 4'd0, 0, 4'd4, 1, 0, 0, 0, 0);
        mem_req = 1; mem_ready = 0;
        #1; check("lumw_frz", {id_ex_en, id_ex_bubble, mem_wb_bubble}, 3'b001);
        step(); step();
        mem_ready = 1;
        #1; check("lumw_stall", {pc_en, id_ex_bubble}, 2'b01);
        step();
        mem_req = 0; mem_ready = 0;
        #1; check("lumw_done", pc_en, 1); check("lumw_cnt", stall_cnt, 3);
        step();
        set_idle(); step(); step();

        // Taken branch flush, suppressed under freeze and stall
        put(4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 1, 0);
        #1; check("flush_on", if_id_flush, 1); step();
        set_idle();
        #1; check("flush_once", if_id_flush, 0); step();
        put(4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 1, 0);
        mem_req = 1; mem_ready = 0;
        #1; check("flush_frz", if_id_flush, 0); step();
        set_idle(); mem_ready = 1; step();
        put(4'd0, 0, 4'd0, 0, 4'd3, 1, 1, 0, 0, 0); step();
        put(4'd3, 1, 4'd0, 0, 4'd0, 0, 0, 1, 1, 0);
        #1; check("flush_stl", if_id_flush, 0); step(); step();
        #1; check("flush_after", if_id_flush, 1); step();
        set_idle(); step(); step();

        // HLT -> halted DC+1 cycles later and sticky
        do_reset();
        put(4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 0, 1);
        #1; check("hlt_t0", halted, 0); step();
        set_idle();
        for (int i = 1; i <= DC + 1; i++) begin
            #1; check("hlt_wait", halted, (i == DC + 1) ? 1 : 0); step();
        end
        for (int i = 0; i < 3; i++) begin
            #1; check("hlt_stay", {pc_en, halted}, 2'b01); step();
        end
        // Reset mid-drain
        do_reset();
        put(4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 0, 1); step();
        set_idle(); step();
        do_reset();
        put(4'd3, 1, 4'd2, 1, 4'd4, 1, 0, 1, 0, 0);
        #1; check("rst_drain", {pc_en, halted}, 2'b10); step();
        set_idle();
        for (int i = 0; i < DC + 2; i++) step();
        #1; check("rst_drain_nohalt", halted, 0);

        // HLT together with a taken branch is ignored
        do_reset();
        put(4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 1, 1);
        #1; check("hltbr_flush", if_id_flush, 1); step();
        set_idle();
        for (int i = 0; i < DC + 3; i++) step();
        #1; check("hltbr_nohalt", halted, 0);

        // Counter saturation
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < CNT_MAX + 5; i++) step();
        #1; check("cnt_sat", stall_cnt, CNT_MAX);
        mem_ready = 1; step();
        set_idle(); step();

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                id_valid     = $urandom_range(0, 3) != 0;
                id_srcA      = 4'($urandom_range(0, 3));
                id_srcB      = 4'($urandom_range(0, 3));
                id_srcA_used = $urandom_range(0, 1);
                id_srcB_used = $urandom_range(0, 1);
                id_dst       = 4'($urandom_range(0, 3));
                id_is_load   = $urandom_range(0, 3) == 0;
                id_wr_en     = id_is_load | 1'($urandom_range(0, 1));
                id_is_br_reg = $urandom_range(0, 4) == 0;
                id_br_taken  = $urandom_range(0, 5) == 0;
                id_hlt       = $urandom_range(0, 50) == 0;
                mem_req      = $urandom_range(0, 3) == 0;
                mem_ready    = $urandom_range(0, 2) != 0;
                step();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
